// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the cache-to-memory bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Number of bus beats needed to move one cache block.
  function automatic int calc_beats(input int block_width, input int dma_data_width);
    return block_width / dma_data_width;
  endfunction

  // Width of an index into num entries, never narrower than one bit.
  function automatic int id_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping to the lowest index. Works for any request count.
module rr_picker #(
  parameter int num_req_p = 4,
  parameter int id_w_p    = 2
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [id_w_p-1:0]    ptr_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [id_w_p-1:0]    grant_id_o,
  output logic                 valid_o
);

  // Two ordered scans: upper segment [ptr..N-1] first, then the wrap from 0.
  always_comb begin
    logic found;
    found      = 1'b0;
    grant_o    = '0;
    grant_id_o = '0;
    for (int j = 0; j < num_req_p; j++) begin
      if (!found && (j >= int'(ptr_i)) && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        grant_id_o = id_w_p'(j);
      end
    end
    for (int j = 0; j < num_req_p; j++) begin
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        grant_id_o = id_w_p'(j);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and block-transfer sequencer for the shared
// cache-to-memory bus.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | bus free; accept the round-robin winner when memory is ready
// ACTIVE  | grant held; count data beats until the block is complete
// RELEASE | one drain cycle with grant still up; rotate priority pointer
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int num_caches_p     = 4,
  parameter int block_width_p    = 16,
  parameter int dma_data_width_p = 2
) (
  input  logic                                 clk_i,
  input  logic                                 nreset_i,
  input  logic [num_caches_p-1:0]              req_i,
  output logic [num_caches_p-1:0]              yumi_o,
  output logic [num_caches_p-1:0]              grant_o,
  output logic [id_width(num_caches_p)-1:0]    grant_id_o,
  output logic                                 busy_o,
  input  logic                                 mem_ready_i,
  input  logic                                 beat_i,
  output logic                                 done_o
);

  localparam int beats_lp = calc_beats(block_width_p, dma_data_width_p);
  localparam int cnt_w_lp = $clog2(beats_lp) + 1;
  localparam int id_w_lp  = id_width(num_caches_p);
  localparam logic [cnt_w_lp-1:0] last_beat_lp = cnt_w_lp'(beats_lp - 1);
  localparam logic [id_w_lp-1:0]  last_id_lp   = id_w_lp'(num_caches_p - 1);

  arb_state_e                state_r, state_n;
  logic [cnt_w_lp-1:0]       cnt_r, cnt_n;
  logic [id_w_lp-1:0]        ptr_r, ptr_n;
  logic [id_w_lp-1:0]        grant_id_r, grant_id_n;
  logic [num_caches_p-1:0]   grant_r, grant_n;
  logic [num_caches_p-1:0]   pick_grant;
  logic [id_w_lp-1:0]        pick_id;
  logic                      pick_valid;
  logic                      accept;
  logic                      last_beat;

  rr_picker #(
    .num_req_p (num_caches_p),
    .id_w_p    (id_w_lp)
  ) u_picker (
    .req_i      (req_i),
    .ptr_i      (ptr_r),
    .grant_o    (pick_grant),
    .grant_id_o (pick_id),
    .valid_o    (pick_valid)
  );

  // Handshake strobes; forced low while reset is asserted so nothing leaks out.
  always_comb begin
    accept    = (state_r == IDLE) && mem_ready_i && pick_valid;
    last_beat = (state_r == ACTIVE) && beat_i && (cnt_r == last_beat_lp);
    yumi_o    = (nreset_i && accept) ? pick_grant : '0;
    done_o    = nreset_i && last_beat;
  end

  // Next-state, beat counter, grant capture and pointer rotation.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    ptr_n      = ptr_r;
    grant_n    = grant_r;
    grant_id_n = grant_id_r;
    case (state_r)
      IDLE: begin
        if (accept) begin
          grant_n    = pick_grant;
          grant_id_n = pick_id;
          cnt_n      = '0;
          state_n    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (beat_i) begin
          cnt_n = cnt_r + cnt_w_lp'(1);
          if (last_beat) state_n = RELEASE;
        end
      end
      RELEASE: begin
        ptr_n      = (grant_id_r == last_id_lp) ? '0 : grant_id_r + id_w_lp'(1);
        grant_n    = '0;
        grant_id_n = '0;
        state_n    = IDLE;
      end
      default: begin
        grant_n    = '0;
        grant_id_n = '0;
        state_n    = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      ptr_r      <= '0;
      grant_r    <= '0;
      grant_id_r <= '0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      ptr_r      <= ptr_n;
      grant_r    <= grant_n;
      grant_id_r <= grant_id_n;
    end
  end

  assign grant_o    = grant_r;
  assign grant_id_o = grant_id_r;
  assign busy_o     = (state_r != IDLE);

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (!nreset_i)
    $onehot0(grant_o));
  a_yumi_onehot0: assert property (@(posedge clk_i) disable iff (!nreset_i)
    $onehot0(yumi_o));
  a_yumi_subset: assert property (@(posedge clk_i) disable iff (!nreset_i)
    ((yumi_o & ~req_i) == '0));
  for (genvar g = 0; g < num_caches_p; g++) begin : g_req_hold
    a_req_hold: assert property (@(posedge clk_i) disable iff (!nreset_i)
      (req_i[g] && !yumi_o[g]) |=> req_i[g]);
  end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a 4-cache instance with 8-beat blocks
// and a 3-cache instance with single-beat blocks.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] req_a;
  logic       mem_ready_a, beat_a;
  logic [3:0] yumi_a, grant_a;
  logic [1:0] grant_id_a;
  logic       busy_a, done_a;

  logic [2:0] req_b;
  logic       mem_ready_b, beat_b;
  logic [2:0] yumi_b, grant_b;
  logic [1:0] grant_id_b;
  logic       busy_b, done_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int sb[$];
  int ptr_m  = 0;
  int ptr_b  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  bus_arbiter #(.num_caches_p(4), .block_width_p(16), .dma_data_width_p(2)) dut_a (
    .clk_i(clk), .nreset_i(nreset), .req_i(req_a), .yumi_o(yumi_a),
    .grant_o(grant_a), .grant_id_o(grant_id_a), .busy_o(busy_a),
    .mem_ready_i(mem_ready_a), .beat_i(beat_a), .done_o(done_a)
  );

  bus_arbiter #(.num_caches_p(3), .block_width_p(4), .dma_data_width_p(4)) dut_b (
    .clk_i(clk), .nreset_i(nreset), .req_i(req_b), .yumi_o(yumi_b),
    .grant_o(grant_b), .grant_id_o(grant_id_b), .busy_o(busy_b),
    .mem_ready_i(mem_ready_b), .beat_i(beat_b), .done_o(done_b)
  );

  function automatic int pick(input logic [3:0] r, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = (p + i) % n;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [3:0] v);
    int r;
    int cnt;
    r = -1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        r = i;
        cnt++;
      end
    end
    if (cnt != 1) r = -1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    nreset = 1'b0;
    req_a = '0; req_b = '0;
    beat_a = 1'b0; beat_b = 1'b0;
    tick();
    @(negedge clk);
    nreset = 1'b1;
    tick();
    ptr_m = 0;
    ptr_b = 0;
  endtask

  // One full transaction on dut_a; caller has req_a/mem_ready_a set at posedge+1.
  task automatic run_txn(input logic [15:0] pat, input int pat_len, output int yumi_cyc);
    int exp_id, got_id, beats, k;
    logic b, exp_done, fin;
    logic [3:0] exp_oh;
    sb.push_back(pick(req_a, ptr_m, 4));
    @(negedge clk);
    yumi_cyc = cyc;
    got_id = oh_idx(yumi_a);
    exp_id = sb.pop_front();
    checks++;
    if (got_id != exp_id) begin
      errors++;
      $display("FAIL yumi_winner: yumi=%b (idx %0d) expected idx %0d", yumi_a, got_id, exp_id);
    end
    if (exp_id < 0) exp_id = 0;
    exp_oh = 4'(1) << exp_id;
    tick();
    req_a[exp_id] = 1'b0;
    beats = 0; k = 0; fin = 1'b0;
    while (!fin && k < 40) begin
      b = (k < pat_len) ? pat[k] : 1'b1;
      beat_a = b;
      exp_done = b && (beats == 7);
      @(negedge clk);
      checks++;
      if (busy_a !== 1'b1 || grant_a !== exp_oh || grant_id_a !== 2'(exp_id) || yumi_a !== 4'b0) begin
        errors++;
        $display("FAIL active_hold: busy=%b grant=%b id=%0d yumi=%b expected busy=1 grant=%b id=%0d yumi=0000",
                 busy_a, grant_a, grant_id_a, yumi_a, exp_oh, exp_id);
      end
      checks++;
      if (done_a !== exp_done) begin
        errors++;
        $display("FAIL done_timing: done=%b expected %b at beat count %0d", done_a, exp_done, beats);
      end
      if (b) beats++;
      fin = exp_done;
      tick();
      k++;
    end
    beat_a = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b1 || grant_a !== exp_oh || done_a !== 1'b0 || yumi_a !== 4'b0) begin
      errors++;
      $display("FAIL release: busy=%b grant=%b done=%b yumi=%b expected busy=1 grant=%b done=0 yumi=0000",
               busy_a, grant_a, done_a, yumi_a, exp_oh);
    end
    tick();
    ptr_m = (exp_id + 1) % 4;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    req_a = 4'b1111; mem_ready_a = 1'b1; beat_a = 1'b1;
    req_b = 3'b111;  mem_ready_b = 1'b1; beat_b = 1'b1;
    #12;
    checks++;
    if (yumi_a !== 4'b0 || grant_a !== 4'b0 || grant_id_a !== 2'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: yumi=%b grant=%b id=%0d busy=%b done=%b expected all zero",
               yumi_a, grant_a, grant_id_a, busy_a, done_a);
    end
    checks++;
    if (yumi_b !== 3'b0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs_b: yumi=%b busy=%b done=%b expected 0", yumi_b, busy_b, done_b);
    end
    mem_ready_b = 1'b0;
    pulse_reset();
  endtask

  task automatic test_single();
    int y;
    req_a = 4'b0100;
    run_txn(16'hFFFF, 16, y);
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || grant_a !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_release: busy=%b grant=%b expected busy=0 grant=0000", busy_a, grant_a);
    end
    tick();
    req_a = 4'b1001;
    run_txn(16'hFFFF, 16, y);
  endtask

  task automatic test_round_robin();
    int y[5];
    pulse_reset();
    req_a = 4'b1111;
    for (int t = 0; t < 4; t++) run_txn(16'hFFFF, 16, y[t]);
    req_a = 4'b0001;
    run_txn(16'hFFFF, 16, y[4]);
    for (int t = 1; t < 5; t++) begin
      checks++;
      if (y[t] - y[t-1] != 10) begin
        errors++;
        $display("FAIL txn_spacing: %0d cycles between yumis expected 10", y[t] - y[t-1]);
      end
    end
  endtask

  task automatic test_mem_ready();
    int y;
    mem_ready_a = 1'b0;
    req_a = 4'b0001;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      checks++;
      if (yumi_a !== 4'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL mem_not_ready: yumi=%b busy=%b expected 0000/0", yumi_a, busy_a);
      end
      tick();
    end
    mem_ready_a = 1'b1;
    run_txn(16'hFFFF, 16, y);
  endtask

  task automatic test_beat_gaps();
    int y;
    logic [15:0] gap_pat;
    gap_pat = 16'b0000_0111_1101_1001;
    beat_a = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL idle_beat: done=%b busy=%b expected 0/0", done_a, busy_a);
      end
      tick();
    end
    req_a = 4'b0010;
    run_txn(gap_pat, 11, y);
    req_a = 4'b1000;
    run_txn(16'hFFFF, 16, y);
  endtask

  task automatic test_reset_mid();
    int y;
    req_a = 4'b0010;
    @(negedge clk);
    checks++;
    if (yumi_a !== 4'b0010) begin
      errors++;
      $display("FAIL mid_yumi: yumi=%b expected 0010", yumi_a);
    end
    tick();
    req_a = 4'b0000;
    beat_a = 1'b1;
    tick(); tick(); tick();
    #2;
    nreset = 1'b0;
    req_a = 4'b0011;
    #1;
    checks++;
    if (busy_a !== 1'b0 || grant_a !== 4'b0 || grant_id_a !== 2'd0 || yumi_a !== 4'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy=%b grant=%b id=%0d yumi=%b done=%b expected all zero",
               busy_a, grant_a, grant_id_a, yumi_a, done_a);
    end
    req_a = 4'b0000;
    beat_a = 1'b0;
    tick();
    @(negedge clk);
    nreset = 1'b1;
    tick();
    ptr_m = 0;
    req_a = 4'b0011;
    run_txn(16'hFFFF, 16, y);
    run_txn(16'hFFFF, 16, y);
  endtask

  task automatic test_three_caches();
    int exp_id, got_id, last_y;
    pulse_reset();
    req_b = 3'b111; mem_ready_b = 1'b1; beat_b = 1'b1;
    last_y = -1;
    for (int t = 0; t < 4; t++) begin
      sb.push_back(pick({1'b0, req_b}, ptr_b, 3));
      @(negedge clk);
      got_id = oh_idx({1'b0, yumi_b});
      exp_id = sb.pop_front();
      checks++;
      if (got_id != exp_id || got_id != (t % 3)) begin
        errors++;
        $display("FAIL three_winner: yumi=%b (idx %0d) expected idx %0d", yumi_b, got_id, exp_id);
      end
      if (last_y >= 0) begin
        checks++;
        if (cyc - last_y != 3) begin
          errors++;
          $display("FAIL three_spacing: %0d cycles between yumis expected 3", cyc - last_y);
        end
      end
      last_y = cyc;
      tick();
      @(negedge clk);
      checks++;
      if (busy_b !== 1'b1 || grant_id_b !== 2'(exp_id) || done_b !== 1'b1) begin
        errors++;
        $display("FAIL three_active: busy=%b id=%0d done=%b expected busy=1 id=%0d done=1",
                 busy_b, grant_id_b, done_b, exp_id);
      end
      tick();
      @(negedge clk);
      checks++;
      if (busy_b !== 1'b1 || done_b !== 1'b0 || grant_b !== 3'(1 << exp_id)) begin
        errors++;
        $display("FAIL three_release: busy=%b done=%b grant=%b expected busy=1 done=0 grant=%b",
                 busy_b, done_b, grant_b, 3'(1 << exp_id));
      end
      tick();
      ptr_b = (exp_id + 1) % 3;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mem_ready();
    test_beat_gaps();
    test_reset_mid();
    test_three_caches();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
